// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit downstream memory port between the instruction fetcher and the LSQ.
// One transaction in flight at a time; fetch responses made stale by a flush are dropped.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        i_mem_read,
   input  logic [31:0] i_mem_address,
   output logic        i_mem_resp,
   output logic [63:0] i_mem_rdata,
   input  logic        lsq_mem_read,
   input  logic        lsq_mem_write,
   input  logic [3:0]  lsq_mem_byte_enable,
   input  logic [31:0] lsq_mem_address,
   input  logic [31:0] lsq_mem_wdata,
   output logic        lsq_mem_resp,
   output logic [31:0] lsq_mem_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_byte_enable,
   output logic [63:0] mem_wdata,
   input  logic        mem_resp,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StFetch, StLsq} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             drop_q, drop_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic             write_q, write_d;

   logic lsq_req, starved, lsq_wins, fetch_wins, hi;
   logic unused_addr;

   assign lsq_req     = lsq_mem_read | lsq_mem_write;
   assign starved     = (starve_q == CNT_W'(STARVE_LIMIT));
   assign lsq_wins    = lsq_req & ~(i_mem_read & starved);
   assign fetch_wins  = i_mem_read & ~lsq_wins;
   assign hi          = addr_q[2];
   assign unused_addr = ^addr_q[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         starve_q <= '0;
         drop_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         drop_q   <= drop_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         write_q  <= write_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      drop_d   = drop_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      write_d  = write_q;
      unique case (state_q)
         StIdle: begin
            drop_d = 1'b0;
            if (lsq_wins) begin
               state_d = StLsq;
               addr_d  = lsq_mem_address;
               wdata_d = lsq_mem_wdata;
               be_d    = lsq_mem_byte_enable;
               write_d = lsq_mem_write;  // read+write together is treated as a write
               if (!i_mem_read) starve_d = '0;
               else if (!starved) starve_d = starve_q + 1'b1;
            end else if (fetch_wins) begin
               state_d  = StFetch;
               addr_d   = i_mem_address;
               wdata_d  = '0;
               be_d     = '0;
               write_d  = 1'b0;
               starve_d = '0;
            end
         end
         StFetch: begin
            if (mem_resp) begin
               state_d = StIdle;
               drop_d  = 1'b0;
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         StLsq: begin
            if (mem_resp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_byte_enable = '0;
      mem_wdata       = '0;
      i_mem_resp      = 1'b0;
      i_mem_rdata     = '0;
      lsq_mem_resp    = 1'b0;
      lsq_mem_rdata   = '0;
      unique case (state_q)
         StFetch: begin
            mem_read    = 1'b1;
            mem_address = {addr_q[31:3], 3'b000};
            // A flush landing in the completion cycle also makes this data stale.
            if (mem_resp && !drop_q && !flush && !rst) begin
               i_mem_resp  = 1'b1;
               i_mem_rdata = hi ? {32'h0000_0013, mem_rdata[63:32]} : mem_rdata;
            end
         end
         StLsq: begin
            mem_read    = ~write_q;
            mem_write   = write_q;
            mem_address = {addr_q[31:3], 3'b000};
            mem_wdata   = {wdata_q, wdata_q};
            if (write_q) mem_byte_enable = hi ? {be_q, 4'b0000} : {4'b0000, be_q};
            if (mem_resp && !rst) begin
               lsq_mem_resp  = 1'b1;
               lsq_mem_rdata = hi ? mem_rdata[63:32] : mem_rdata[31:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(lsq_mem_read && lsq_mem_write))
            else $error("lsq_mem_read and lsq_mem_write asserted together");
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table through a scoreboard, plus hand sequences for
// contention/starvation, flush during fetch and reset mid-transaction.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        i_mem_read;
   logic [31:0] i_mem_address;
   logic        i_mem_resp;
   logic [63:0] i_mem_rdata;
   logic        lsq_mem_read, lsq_mem_write;
   logic [3:0]  lsq_mem_byte_enable;
   logic [31:0] lsq_mem_address, lsq_mem_wdata;
   logic        lsq_mem_resp;
   logic [31:0] lsq_mem_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_address;
   logic [7:0]  mem_byte_enable;
   logic [63:0] mem_wdata;
   logic        mem_resp = 1'b0;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
      .lsq_mem_read(lsq_mem_read), .lsq_mem_write(lsq_mem_write),
      .lsq_mem_byte_enable(lsq_mem_byte_enable), .lsq_mem_address(lsq_mem_address),
      .lsq_mem_wdata(lsq_mem_wdata), .lsq_mem_resp(lsq_mem_resp),
      .lsq_mem_rdata(lsq_mem_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   typedef struct {
      string       name;
      bit          fetch;
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [63:0] rdata;
      int          lat;
      logic [31:0] x_addr;
      logic [7:0]  x_be;
      logic [63:0] x_up;
   } vec_t;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t sb[$];
   vec_t vt[9];
   vec_t mon_e;
   bit   sb_on = 1'b1;
   int   resp_cnt = 0;
   int   mresp_cnt = 0;
   logic [31:0] grant_log[$];
   logic [31:0] snap_addr;
   logic prev_req = 1'b0;

   // Downstream memory model
   bit          resp_en = 1'b1;
   bit          man_resp = 1'b0;
   int          lat = 0;
   int          rcnt = 0;
   logic [63:0] rd_data = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   function automatic vec_t mk(string nm, bit f, bit w, logic [31:0] a, logic [3:0] be,
                               logic [31:0] wd, logic [63:0] rd, int lt, logic [31:0] xa,
                               logic [7:0] xbe, logic [63:0] xu);
      vec_t v;
      v.name = nm; v.fetch = f; v.wr = w; v.addr = a; v.be = be; v.wdata = wd;
      v.rdata = rd; v.lat = lt; v.x_addr = xa; v.x_be = xbe; v.x_up = xu;
      return v;
   endfunction

   always @(negedge clk) begin
      if (!resp_en) begin
         mem_resp  = man_resp;
         mem_rdata = rd_data;
         rcnt      = 0;
      end else if (mem_resp) begin
         mem_resp = 1'b0;
         rcnt     = 0;
      end else if (mem_read || mem_write) begin
         if (rcnt >= lat) begin
            mem_resp  = 1'b1;
            mem_rdata = rd_data;
            rcnt      = 0;
         end else begin
            rcnt++;
         end
      end
   end

   // Monitor: grant checks against the scoreboard head, response checks pop it.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_req = 1'b0;
      end else begin
         if (mem_resp) mresp_cnt++;
         if (!i_mem_resp) check("i_rdata_idle", i_mem_rdata, 64'h0);
         if (!lsq_mem_resp) check("lsq_rdata_idle", {32'h0, lsq_mem_rdata}, 64'h0);
         if ((mem_read || mem_write) && !prev_req) begin
            grant_log.push_back(mem_address);
            snap_addr = mem_address;
            if (sb_on) begin
               if (sb.size() == 0) begin
                  check("grant_unexpected", 64'h1, 64'h0);
               end else begin
                  mon_e = sb[0];
                  check({mon_e.name, "_addr"}, {32'h0, mem_address}, {32'h0, mon_e.x_addr});
                  check({mon_e.name, "_be"}, {56'h0, mem_byte_enable}, {56'h0, mon_e.x_be});
                  check({mon_e.name, "_wr"}, {63'h0, mem_write}, {63'h0, mon_e.wr});
                  check({mon_e.name, "_rd"}, {63'h0, mem_read}, {63'h0, !mon_e.wr});
                  if (mon_e.wr)
                     check({mon_e.name, "_wdata"}, mem_wdata, {mon_e.wdata, mon_e.wdata});
               end
            end
         end else if (mem_read || mem_write) begin
            check("addr_stable", {32'h0, mem_address}, {32'h0, snap_addr});
         end
         prev_req = mem_read || mem_write;
         if (i_mem_resp || lsq_mem_resp) begin
            resp_cnt++;
            if (sb_on) begin
               if (sb.size() == 0) begin
                  check("resp_unexpected", 64'h1, 64'h0);
               end else begin
                  mon_e = sb.pop_front();
                  check({mon_e.name, "_iresp"}, {63'h0, i_mem_resp}, {63'h0, mon_e.fetch});
                  check({mon_e.name, "_lresp"}, {63'h0, lsq_mem_resp}, {63'h0, !mon_e.fetch});
                  if (mon_e.fetch) check({mon_e.name, "_rdata"}, i_mem_rdata, mon_e.x_up);
                  else check({mon_e.name, "_rdata"}, {32'h0, lsq_mem_rdata}, mon_e.x_up);
               end
            end
         end
      end
   end

   task automatic check_idle(input string nm);
      check({nm, "_mem_read"}, {63'h0, mem_read}, 64'h0);
      check({nm, "_mem_write"}, {63'h0, mem_write}, 64'h0);
      check({nm, "_mem_address"}, {32'h0, mem_address}, 64'h0);
      check({nm, "_mem_be"}, {56'h0, mem_byte_enable}, 64'h0);
      check({nm, "_mem_wdata"}, mem_wdata, 64'h0);
      check({nm, "_i_resp"}, {63'h0, i_mem_resp}, 64'h0);
      check({nm, "_lsq_resp"}, {63'h0, lsq_mem_resp}, 64'h0);
      check({nm, "_i_rdata"}, i_mem_rdata, 64'h0);
      check({nm, "_lsq_rdata"}, {32'h0, lsq_mem_rdata}, 64'h0);
   endtask

   task automatic drive(input vec_t v);
      i_mem_read          = v.fetch;
      i_mem_address       = v.fetch ? v.addr : 32'h0;
      lsq_mem_read        = !v.fetch && !v.wr;
      lsq_mem_write       = !v.fetch && v.wr;
      lsq_mem_address     = v.fetch ? 32'h0 : v.addr;
      lsq_mem_byte_enable = v.be;
      lsq_mem_wdata       = v.wdata;
   endtask

   task automatic run_vec(input vec_t v);
      int c0, n;
      lat     = v.lat;
      rd_data = v.rdata;
      sb.push_back(v);
      drive(v);
      c0 = resp_cnt;
      n  = 0;
      while (resp_cnt == c0 && n < 50) begin
         tick();
         n++;
      end
      if (resp_cnt == c0) begin
         check({v.name, "_timeout"}, 64'h1, 64'h0);
         sb.delete();
      end
      i_mem_read    = 1'b0;
      lsq_mem_read  = 1'b0;
      lsq_mem_write = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n, c0, m0;
      logic [31:0] g, xg;

      rst = 1'b1; flush = 1'b0; i_mem_read = 1'b0; i_mem_address = '0;
      lsq_mem_read = 1'b0; lsq_mem_write = 1'b0; lsq_mem_byte_enable = '0;
      lsq_mem_address = '0; lsq_mem_wdata = '0;

      vt[0] = mk("fetch_hi", 1, 0, 32'h0000_1004, 4'h0, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 3,
                 32'h0000_1000, 8'h00, 64'h0000_0013_AAAA_BBBB);
      vt[1] = mk("fetch_lo", 1, 0, 32'h0000_2000, 4'h0, 32'h0, 64'h1111_2222_3333_4444, 0,
                 32'h0000_2000, 8'h00, 64'h1111_2222_3333_4444);
      vt[2] = mk("st_hi", 0, 1, 32'h0000_2004, 4'b0011, 32'h1234_5678, 64'h0, 2,
                 32'h0000_2000, 8'b0011_0000, 64'h0);
      vt[3] = mk("st_lo", 0, 1, 32'h0000_2008, 4'b1100, 32'hCAFE_BABE, 64'h0, 1,
                 32'h0000_2008, 8'h0C, 64'h0);
      vt[4] = mk("ld_lo", 0, 0, 32'h0000_4000, 4'hF, 32'h5555_AAAA, 64'hDEAD_BEEF_0BAD_F00D, 2,
                 32'h0000_4000, 8'h00, 64'h0BAD_F00D);
      vt[5] = mk("ld_hi", 0, 0, 32'h0000_400C, 4'h0, 32'h0, 64'hDEAD_BEEF_0BAD_F00D, 1,
                 32'h0000_4008, 8'h00, 64'hDEAD_BEEF);
      vt[6] = mk("st_full_hi", 0, 1, 32'h0000_7FFC, 4'hF, 32'hA5A5_0F0F, 64'h0, 0,
                 32'h0000_7FF8, 8'hF0, 64'h0);
      vt[7] = mk("fetch_top", 1, 0, 32'hFFFF_FFFC, 4'h0, 32'h0, 64'h0123_4567_89AB_CDEF, 4,
                 32'hFFFF_FFF8, 8'h00, 64'h0000_0013_0123_4567);
      vt[8] = mk("fetch_after_flush", 1, 0, 32'h0000_3000, 4'h0, 32'h0,
                 64'h0F0F_1E1E_2D2D_3C3C, 2, 32'h0000_3000, 8'h00, 64'h0F0F_1E1E_2D2D_3C3C);

      repeat (3) tick();
      check_idle("reset");
      rst = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) run_vec(vt[k]);

      // Flush held through an LSQ load and idle cycles must not affect it.
      flush = 1'b1;
      run_vec(vt[5]);
      flush = 1'b0;
      tick();

      // Flush one cycle after a fetch grant: the response is dropped.
      sb_on = 1'b0; lat = 3; rd_data = 64'hBADB_ADBA_DBAD_BADB;
      c0 = resp_cnt; m0 = mresp_cnt;
      i_mem_read = 1'b1; i_mem_address = 32'h0000_3100;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n = 0;
      while (mresp_cnt == m0 && n < 50) begin
         tick();
         n++;
      end
      check("flush_mem_resp_seen", {63'h0, mresp_cnt != m0}, 64'h1);
      check("flush_resp_dropped", resp_cnt - c0, 64'h0);
      i_mem_read = 1'b0;
      tick();
      sb_on = 1'b1;
      run_vec(vt[8]);

      // Both requesters held: four LSQ grants, then fetch, repeating.
      sb_on = 1'b0; lat = 1; rd_data = '0;
      grant_log.delete();
      i_mem_read = 1'b1; i_mem_address = 32'h0000_5000;
      lsq_mem_read = 1'b1; lsq_mem_address = 32'h0000_6000;
      n = 0;
      while (grant_log.size() < 10 && n < 300) begin
         tick();
         n++;
      end
      i_mem_read = 1'b0; lsq_mem_read = 1'b0;
      repeat (10) tick();
      for (int k = 0; k < 10; k++) begin
         g  = (k < grant_log.size()) ? grant_log[k] : 32'hxxxx_xxxx;
         xg = (k == 4 || k == 9) ? 32'h0000_5000 : 32'h0000_6000;
         check($sformatf("grant_order_%0d", k), {32'h0, g}, {32'h0, xg});
      end
      sb_on = 1'b1;

      // Reset two cycles into an LSQ store; a late mem_resp must not produce a response.
      resp_en = 1'b0; man_resp = 1'b0; rd_data = 64'h1111_2222_3333_4444;
      tick();
      sb_on = 1'b0;
      c0 = resp_cnt;
      lsq_mem_write = 1'b1; lsq_mem_address = 32'h0000_2004;
      lsq_mem_byte_enable = 4'hF; lsq_mem_wdata = 32'h7777_8888;
      tick();
      check("rst_txn_started", {63'h0, mem_write}, 64'h1);
      tick();
      rst = 1'b1; man_resp = 1'b1;
      tick();
      rst = 1'b0; lsq_mem_write = 1'b0;
      check_idle("post_reset");
      man_resp = 1'b0;
      repeat (2) tick();
      check("rst_no_resp", resp_cnt - c0, 64'h0);
      resp_en = 1'b1; sb_on = 1'b1;
      tick();

      run_vec(vt[4]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit downstream memory/cache port between two requesters: the instruction fetcher (read-only, 64-bit fetch pair) and the load/store queue (32-bit read/write).
- Sits between the cpu top and the cache.
- Latches the winning request, sequences one transaction at a time, and steers data and byte enables.
- Discards fetch responses made stale by a pipeline flush.

Parameters:
STARVE_LIMIT, 4, number of consecutive LSQ grants made while a fetch request is pending before fetch is forced to win.
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush (branch mispredict); in-flight fetch data is stale
i_mem_read  in  1  fetch request; held until i_mem_resp
i_mem_address  in  32  fetch address, 4-byte aligned
i_mem_resp  out  1  fetch response, 1-cycle pulse
i_mem_rdata  out  64  two instructions, {pc+4, pc}
lsq_mem_read  in  1  LSQ load request; held until lsq_mem_resp
lsq_mem_write  in  1  LSQ store request; held until lsq_mem_resp
lsq_mem_byte_enable  in  4  store byte mask
lsq_mem_address  in  32  LSQ address, 4-byte aligned
lsq_mem_wdata  in  32  store data
lsq_mem_resp  out  1  LSQ response, 1-cycle pulse
lsq_mem_rdata  out  32  load data
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_address  out  32  downstream address, bits [2:0] always 0
mem_byte_enable  out  8  downstream byte mask
mem_wdata  out  64  downstream write data
mem_resp  in  1  downstream completion
mem_rdata  in  64  downstream read data

Behaviour:
- **FSM states:** IDLE, FETCH, LSQ.
- **Reset:**
  - State IDLE, starve_cnt 0, drop flag 0, latched registers 0.
  - All outputs 0.
  - Reset in FETCH or LSQ returns to IDLE next edge and abandons the transaction; no resp is issued.
- **Arbitration (IDLE only, sampled at posedge):**
  - LSQ request = lsq_mem_read | lsq_mem_write.
  - LSQ wins when both are pending, unless starve_cnt == STARVE_LIMIT.
  - A lone requester always wins.
- **Starvation counter:**
  - starve_cnt increments on each LSQ grant made while i_mem_read is high.
  - Clears on any fetch grant, or on an LSQ grant with i_mem_read low.
  - Saturates at STARVE_LIMIT.
- **Grant latency:** on a grant, the address, wdata, byte enable, op and addr[2] are latched. The downstream request is asserted from the next cycle, driven from registers only, and is stable until mem_resp.
- **Completion:**
  - In FETCH/LSQ, the cycle with mem_resp=1 pulses the matching upstream resp combinationally in the same cycle and moves to IDLE.
  - Minimum of one IDLE cycle between transactions, so back-to-back grants are 1 cycle apart after resp.
- **Downstream address:** mem_address = {addr[31:3], 3'b000}.
- **LSQ steering (hi = latched addr[2]):**
  - mem_byte_enable = hi ? {be, 4'b0} : {4'b0, be} on writes; 8'h00 on reads.
  - mem_wdata = {wdata, wdata}.
  - lsq_mem_rdata = hi ? mem_rdata[63:32] : mem_rdata[31:0].
- **Fetch steering:**
  - mem_read only, mem_byte_enable 8'h00.
  - i_mem_rdata = hi ? {32'h0000_0013, mem_rdata[63:32]} : mem_rdata (NOP fills the second slot past the line half).
- **Flush:**
  - flush in FETCH (including the mem_resp cycle) sets the drop flag.
  - On mem_resp with drop set, i_mem_resp stays 0, the FSM returns to IDLE and drop clears.
  - flush in IDLE or LSQ has no effect.
  - The fetcher re-presents its new address; arbitration re-samples it.
- **Illegal input:** lsq_mem_read & lsq_mem_write both high is treated as a write; a simulation assertion fires.
- **Upstream outputs:** i_mem_rdata and lsq_mem_rdata are 0 when the matching resp is 0.
- **Protocol:** requests deasserted mid-transaction are ignored until completion.

Test Plan:
- **Lone fetch:** i_mem_read, addr 0x0000_1004; mem_resp after 3 cycles with rdata 0xAAAA_BBBB_CCCC_DDDD -> mem_address 0x1000, mem_read from cycle 1; i_mem_resp pulses with i_mem_rdata 0x0000_0013_AAAA_BBBB.
- **LSQ store, upper half:** lsq_mem_write, addr 0x2004, be 4'b0011, wdata 0x1234_5678 -> mem_byte_enable 8'b0011_0000, mem_wdata 0x1234_5678_1234_5678, mem_address 0x2000; one lsq_mem_resp pulse.
- **Contention/starvation:** both requesters held continuously, STARVE_LIMIT=4 -> grant order LSQ, LSQ, LSQ, LSQ, FETCH, LSQ...; starve_cnt returns to 0 after the fetch grant.
- **Flush during fetch:** flush pulses 1 cycle after the fetch grant -> mem_resp arrives, i_mem_resp stays 0; the next fetch request at 0x3000 is granted and responds normally.
- **Load, lower half:** lsq_mem_read, addr 0x4000, mem_rdata 0xDEAD_BEEF_0BAD_F00D -> lsq_mem_rdata 0x0BAD_F00D, mem_byte_enable 8'h00.
- **Reset mid-LSQ:** rst asserted 2 cycles into an LSQ transaction -> next cycle all outputs 0, state IDLE, no lsq_mem_resp even if mem_resp arrives.
